// File: rtl/onchip_ram_dp.sv
// True dual-port Avalon-MM RAM; read data and readdatavalid arrive READ_LATENCY (1 or 2) cycles after the read.
// No waitrequest: every access is taken the cycle it is presented, and clken=0 freezes all state.
module onchip_ram_dp #(
   parameter int    DATA_WIDTH   = 32,
   parameter int    ADDR_WIDTH   = 13,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "onchip_ram_dp.hex",
   parameter int    CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clken,
   input  logic                    reset_req,

   input  logic [ADDR_WIDTH-1:0]   s1_address,
   input  logic                    s1_chipselect,
   input  logic                    s1_read,
   input  logic                    s1_write,
   input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
   input  logic [DATA_WIDTH-1:0]   s1_writedata,
   output logic [DATA_WIDTH-1:0]   s1_readdata,
   output logic                    s1_readdatavalid,

   input  logic [ADDR_WIDTH-1:0]   s2_address,
   input  logic                    s2_chipselect,
   input  logic                    s2_read,
   input  logic                    s2_write,
   input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
   input  logic [DATA_WIDTH-1:0]   s2_writedata,
   output logic [DATA_WIDTH-1:0]   s2_readdata,
   output logic                    s2_readdatavalid,

   output logic [CNT_WIDTH-1:0]    collision_count,
   input  logic                    collision_clr
);

   localparam int                   NB      = DATA_WIDTH / 8;
   localparam int                   DEPTH   = 2 ** ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // The array image comes from INIT_FILE in the FPGA build flow; nothing consumes it at run time.
   logic unused_init_file;
   assign unused_init_file = (INIT_FILE != "");

   logic                             acc_en;
   logic [1:0]                       wr;
   logic [1:0]                       rd;
   logic [1:0][ADDR_WIDTH-1:0]       addr;
   logic [1:0][DATA_WIDTH-1:0]       rd_dat;
   logic [1:0]                       rd_vld;
   logic                             overlap;

   assign acc_en  = clken & ~reset_req;
   assign wr[0]   = s1_chipselect & s1_write;
   assign wr[1]   = s2_chipselect & s2_write;
   assign rd[0]   = s1_chipselect & s1_read & ~s1_write;
   assign rd[1]   = s2_chipselect & s2_read & ~s2_write;
   assign addr[0] = s1_address;
   assign addr[1] = s2_address;

   // s1 is assigned last so it owns every lane both ports write at the same address.
   always_ff @(posedge clk) begin
      if (acc_en) begin
         for (int i = 0; i < NB; i++) begin
            if (wr[1] && s2_byteenable[i])
               mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
            if (wr[0] && s1_byteenable[i])
               mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
         end
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [DATA_WIDTH-1:0] ram_q;
      logic                  ram_q_vld;

      // Sampled before this edge's writes land, so a cross-port read of the same word sees old data.
      always_ff @(posedge clk) begin
         if (reset) begin
            ram_q     <= '0;
            ram_q_vld <= 1'b0;
         end else if (clken) begin
            ram_q_vld <= rd[p] & ~reset_req;
            if (rd[p] && !reset_req)
               ram_q <= mem[addr[p]];
         end
      end

      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] out_q;
         logic                  out_q_vld;

         always_ff @(posedge clk) begin
            if (reset) begin
               out_q     <= '0;
               out_q_vld <= 1'b0;
            end else if (clken) begin
               out_q_vld <= ram_q_vld;
               if (ram_q_vld)
                  out_q <= ram_q;
            end
         end

         assign rd_dat[p] = out_q;
         assign rd_vld[p] = out_q_vld;
      end else begin : g_lat1
         assign rd_dat[p] = ram_q;
         assign rd_vld[p] = ram_q_vld;
      end
   end

   assign s1_readdata      = rd_dat[0];
   assign s1_readdatavalid = rd_vld[0];
   assign s2_readdata      = rd_dat[1];
   assign s2_readdatavalid = rd_vld[1];

   assign overlap = acc_en & wr[0] & wr[1] & (s1_address == s2_address)
                  & (|(s1_byteenable & s2_byteenable));

   always_ff @(posedge clk) begin
      if (reset) begin
         collision_count <= '0;
      end else if (clken) begin
         if (collision_clr)
            collision_count <= '0;
         else if (overlap && collision_count != CNT_MAX)
            collision_count <= collision_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Directed bench for onchip_ram_dp at READ_LATENCY=2, 8-bit addresses and a 4-bit collision counter.
module tb_onchip_ram_dp;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset, clken, reset_req;
   logic [7:0]  s1_address, s2_address;
   logic        s1_chipselect, s1_read, s1_write;
   logic        s2_chipselect, s2_read, s2_write;
   logic [3:0]  s1_byteenable, s2_byteenable;
   logic [31:0] s1_writedata, s2_writedata;
   logic [31:0] s1_readdata, s2_readdata;
   logic        s1_readdatavalid, s2_readdatavalid;
   logic [3:0]  collision_count;
   logic        collision_clr;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] cap [16];
   int          n_cap;
   int          idx;

   always #5 clk = ~clk;

   onchip_ram_dp #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (8),
      .READ_LATENCY (LAT),
      .INIT_FILE    (""),
      .CNT_WIDTH    (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .clken            (clken),
      .reset_req        (reset_req),
      .s1_address       (s1_address),
      .s1_chipselect    (s1_chipselect),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_byteenable    (s1_byteenable),
      .s1_writedata     (s1_writedata),
      .s1_readdata      (s1_readdata),
      .s1_readdatavalid (s1_readdatavalid),
      .s2_address       (s2_address),
      .s2_chipselect    (s2_chipselect),
      .s2_read          (s2_read),
      .s2_write         (s2_write),
      .s2_byteenable    (s2_byteenable),
      .s2_writedata     (s2_writedata),
      .s2_readdata      (s2_readdata),
      .s2_readdatavalid (s2_readdatavalid),
      .collision_count  (collision_count),
      .collision_clr    (collision_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0; s1_byteenable = 4'h0;
      s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0; s2_byteenable = 4'h0;
      collision_clr = 1'b0;
   endtask

   task automatic wr(input int p, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      if (p == 0) begin
         s1_chipselect = 1'b1; s1_write = 1'b1; s1_read = 1'b0;
         s1_address = a; s1_writedata = d; s1_byteenable = be;
      end else begin
         s2_chipselect = 1'b1; s2_write = 1'b1; s2_read = 1'b0;
         s2_address = a; s2_writedata = d; s2_byteenable = be;
      end
   endtask

   task automatic rd(input int p, input logic [7:0] a);
      if (p == 0) begin
         s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0; s1_address = a;
      end else begin
         s2_chipselect = 1'b1; s2_read = 1'b1; s2_write = 1'b0; s2_address = a;
      end
   endtask

   function automatic logic [31:0] rdata(input int p);
      return (p != 0) ? s2_readdata : s1_readdata;
   endfunction

   function automatic logic rvld(input int p);
      return (p != 0) ? s2_readdatavalid : s1_readdatavalid;
   endfunction

   // Called one cycle after the read was sampled: valid must stay low until LAT cycles have passed.
   task automatic expect_rd(input string tag, input int p, input logic [31:0] exp);
      for (int k = 1; k < LAT; k++) begin
         check({tag, "_early"}, {31'd0, rvld(p)}, 32'd0);
         tick();
      end
      check({tag, "_vld"}, {31'd0, rvld(p)}, 32'd1);
      check(tag, rdata(p), exp);
   endtask

   initial begin
      reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
      s1_address = 8'h0; s2_address = 8'h0;
      s1_writedata = 32'h0; s2_writedata = 32'h0;
      idle();
      tick(); tick();
      reset = 1'b0;
      check("rst_s1_dat", s1_readdata, 32'h0);
      check("rst_s2_dat", s2_readdata, 32'h0);
      check("rst_s1_vld", {31'd0, s1_readdatavalid}, 32'd0);
      check("rst_s2_vld", {31'd0, s2_readdatavalid}, 32'd0);
      check("rst_cnt", {28'd0, collision_count}, 32'd0);

      // basic write then read, single valid pulse, data held afterwards
      wr(0, 8'h10, 32'hDEADBEEF, 4'hF); tick(); idle();
      rd(0, 8'h10); tick(); idle();
      expect_rd("s1_rd", 0, 32'hDEADBEEF);
      tick();
      check("s1_vld_once", {31'd0, s1_readdatavalid}, 32'd0);
      check("s1_hold", s1_readdata, 32'hDEADBEEF);

      // byteenable=0 write leaves the word alone; port 2 sees port 1's data
      wr(0, 8'h10, 32'h0, 4'h0); tick(); idle();
      rd(1, 8'h10); tick(); idle();
      expect_rd("be0_noop", 1, 32'hDEADBEEF);

      // write/write collisions
      wr(0, 8'h20, 32'h11223344, 4'hF); wr(1, 8'h20, 32'hAABBCCDD, 4'h3); tick(); idle();
      check("coll_cnt1", {28'd0, collision_count}, 32'd1);
      rd(1, 8'h20); tick(); idle();
      expect_rd("ww_s1_wins", 1, 32'h11223344);
      wr(0, 8'h20, 32'h11223344, 4'h3); wr(1, 8'h20, 32'hAABBCCDD, 4'hC); tick(); idle();
      check("coll_disjoint", {28'd0, collision_count}, 32'd1);
      rd(0, 8'h20); tick(); idle();
      expect_rd("ww_merge", 0, 32'hAABB3344);

      // mixed-port read during write
      wr(0, 8'h30, 32'h0, 4'hF); tick();
      wr(0, 8'h30, 32'h55, 4'hF); rd(1, 8'h30); tick(); idle();
      expect_rd("rdw_old", 1, 32'h0);
      rd(1, 8'h30); tick(); idle();
      expect_rd("rdw_new", 1, 32'h55);

      // burst of 8 reads with a 3-cycle clken freeze; reads presented while frozen are dropped
      for (int i = 0; i < 8; i++) begin
         wr(0, 8'(i), 32'h100 + i, 4'hF); tick();
      end
      idle();
      n_cap = 0; idx = 0;
      for (int c = 0; c < 16; c++) begin
         idle();
         clken = !(c >= 4 && c <= 6);
         if (idx < 8) rd(1, idx[7:0]);
         tick();
         if (clken) begin
            if (idx < 8) idx++;
            if (s2_readdatavalid) begin
               if (n_cap < 16) cap[n_cap] = s2_readdata;
               n_cap++;
            end
         end
      end
      clken = 1'b1; idle();
      check("burst_count", n_cap, 32'd8);
      for (int i = 0; i < 8; i++)
         check("burst_dat", cap[i], 32'h100 + i);

      // reset with a read in flight
      rd(0, 8'h10); tick(); idle();
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_mid_vld", {31'd0, s1_readdatavalid}, 32'd0);
      check("rst_mid_dat", s1_readdata, 32'h0);
      check("rst_mid_cnt", {28'd0, collision_count}, 32'd0);
      tick();
      check("rst_mid_vld2", {31'd0, s1_readdatavalid}, 32'd0);
      rd(0, 8'h10); tick(); idle();
      expect_rd("keep_10", 0, 32'hDEADBEEF);
      rd(1, 8'h20); tick(); idle();
      expect_rd("keep_20", 1, 32'hAABB3344);

      // reset_req suppresses array writes, reads and collision counting
      wr(0, 8'h60, 32'h12345678, 4'hF); tick(); idle();
      reset_req = 1'b1;
      wr(0, 8'h60, 32'hFFFFFFFF, 4'hF); wr(1, 8'h60, 32'hFFFFFFFF, 4'hF); tick(); idle();
      rd(1, 8'h60); tick(); idle();
      reset_req = 1'b0;
      check("rreq_nocnt", {28'd0, collision_count}, 32'd0);
      tick();
      check("rreq_rd_drop", {31'd0, s2_readdatavalid}, 32'd0);
      rd(0, 8'h60); tick(); idle();
      expect_rd("rreq_nowr", 0, 32'h12345678);

      // counter saturation, clear priority, clken freeze
      for (int i = 0; i < 17; i++) begin
         wr(0, 8'h50, 32'(i), 4'hF); wr(1, 8'h50, ~32'(i), 4'hF); tick();
      end
      idle();
      check("cnt_sat", {28'd0, collision_count}, 32'd15);
      wr(0, 8'h50, 32'hA5A5A5A5, 4'hF); wr(1, 8'h50, 32'h5A5A5A5A, 4'hF); collision_clr = 1'b1;
      tick(); idle();
      check("clr_prio", {28'd0, collision_count}, 32'd0);
      clken = 1'b0;
      wr(0, 8'h50, 32'hFFFF0000, 4'hF); wr(1, 8'h50, 32'h0000FFFF, 4'hF); tick();
      clken = 1'b1; idle();
      check("clken_cnt_hold", {28'd0, collision_count}, 32'd0);
      rd(0, 8'h50); tick(); idle();
      expect_rd("clken_nowr", 0, 32'hA5A5A5A5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
